usb_ft1248_device: RTL and testbench
====================================

Name: usb_ft1248_device

Overview:
Synthesizable FT1248 responder that models the FTDI side of the 1-bit-MISO / 8-bit-MIOSI FT1248 bus. It is used as the bus partner of the cartridge-side FT1248 master in simulation and in loopback builds. It decodes master commands and answers with ACK/NAK on usb_miso. It moves bytes between the bus and two internal byte FIFOs (host->device RX, device->host TX) and exposes a modem-status register pair.

Parameters:
DEPTH, 16, entries per internal FIFO (power of two, 2..256)

Ports:
clk  in  1  system clock; usb_clk/usb_cs/usb_miosi are driven synchronously to it
reset  in  1  synchronous, active-high reset
usb_clk  in  1  FT1248 clock from master
usb_cs  in  1  FT1248 chip select, active low
usb_miso  out  1  0 = ACK / byte accepted, 1 = NAK / busy
usb_miosi  inout  8  bidirectional data; driven only while this block owns the bus
rx_read  in  1  pop one host->device byte
rx_empty  out  1  RX FIFO empty
rx_rdata  out  8  RX FIFO head
tx_write  in  1  push one device->host byte
tx_wdata  in  8  byte to push
tx_full  out  1  TX FIFO full
host_reset  in  1  reported as modem-status bit0 on READ_MODEM_STATUS
reset_reply  out  1  bit5 of last byte written by WRITE_MODEM_STATUS
flush_seen  out  1  one-cycle pulse per completed WRITE_BUFFER_FLUSH

Behaviour:
- Input stage: usb_clk, usb_cs, usb_miosi registered once. Edges are detected on the registered usb_clk versus its previous value: rise = 0->1, fall = 1->0.
- Outputs usb_miso, the miosi drive value and the output enable are registered.
- Reset values: usb_miso=1, miosi output enable=0, reset_reply=0, flush_seen=0, both FIFOs empty, state IDLE.
- Commands, seen from the master: WRITE 0x00 (host->device), READ 0x40 (device->host), READ_MODEM_STATUS 0x20, WRITE_MODEM_STATUS 0x60, WRITE_BUFFER_FLUSH 0x08. Any other code is NAKed.
- States: IDLE, COMMAND, STATUS, DATA, HOLD.
  - IDLE: registered usb_cs=1, miso=1, bus released. Registered usb_cs=0 -> COMMAND.
  - COMMAND: on rise, capture registered miosi as cmd. On fall -> STATUS.
  - STATUS: on rise, drive miso = ACK condition. ACK condition per command:
    - WRITE: RX FIFO not full.
    - READ: TX FIFO not empty.
    - Modem/flush commands: always ACK.
    - Unknown code: NAK.
  - STATUS, bus drive: for READ and READ_MODEM_STATUS, enable the miosi drive starting the cycle after the STATUS rise.
  - STATUS, on fall: -> DATA if ACK, else -> HOLD.
  - DATA, on each rise: re-evaluate miso and present the outgoing byte; values are held until the next rise.
    - READ: miosi = TX head; miso = TX empty.
    - WRITE: miso = RX full.
    - Modem/flush commands: miso=0 for the first data byte only, 1 afterwards.
    - READ_MODEM_STATUS byte = {7'b0, host_reset}, sampled at the rise.
  - DATA, on each fall with miso=0 (commit):
    - WRITE pushes the registered miosi captured at the rise.
    - READ pops TX.
    - WRITE_MODEM_STATUS latches bit5 into reset_reply.
    - WRITE_BUFFER_FLUSH pulses flush_seen for 1 clk.
    - READ_MODEM_STATUS commits nothing.
  - DATA, fall with miso=1: no commit -> HOLD.
  - HOLD: miso=1, bus released, clock edges ignored until deselect.
- Deselect: registered usb_cs=1 in any state -> IDLE next cycle. Bus is released and miso=1; a partial byte (rise without fall) is discarded with no FIFO change.
- Bus direction: the drive enable is never asserted in COMMAND or for WRITE, WRITE_MODEM_STATUS or WRITE_BUFFER_FLUSH. The enable drops in the same cycle the state leaves STATUS/DATA.
- FIFOs:
  - Same-cycle push+pop allowed.
  - Push when full is ignored; pop when empty is ignored.
  - Pointers wrap modulo DEPTH; counts are log2(DEPTH)+1 bits wide.
  - Local tx_write and bus-side WRITE commits never contend: each FIFO has exactly one writer.
- Reset mid-transaction: back to IDLE, FIFOs cleared, bus released in the next cycle regardless of usb_cs.

Test Plan:
- WRITE, master sends 0xA1,0xB2,0xC3, RX empty -> miso=0 in STATUS and each byte; rx_empty deasserts; rx_rdata pops A1, B2, C3 in order.
- Preload TX with 0x11,0x22; master READs 3 bytes -> bytes 0x11, 0x22 with miso=0; third byte miso=1; state HOLD; TX empty.
- READ with TX empty -> NAK in STATUS; miosi never driven; no pop.
- host_reset=1, READ_MODEM_STATUS -> data byte 0x01 with ACK. WRITE_MODEM_STATUS 0x20 -> reset_reply=1; a later write of 0x00 -> reset_reply=0.
- Fill RX to DEPTH, then WRITE -> NAK in STATUS; rx count stays DEPTH. Unknown command 0x55 -> NAK, HOLD until deselect.
- Raise usb_cs between rise and fall of the 2nd WRITE byte -> only byte 1 stored; IDLE and miso=1 next cycle. WRITE_BUFFER_FLUSH -> exactly one flush_seen pulse.

Source files
------------

// File: rtl/usb_ft1248_device.sv
// rtl/usb_ft1248_device.sv - FT1248 bus responder with host->device and device->host byte FIFOs
//
// usb_ft1248_fifo : single-clock first-word-fall-through byte FIFO.
//   clk, reset          system clock, synchronous active-high reset
//   push, wdata, full   write side; a push while full is dropped
//   pop, rdata, empty   read side; rdata is the current head, a pop while empty is dropped
//
// usb_ft1248_device : FTDI-side partner of the FT1248 master.
//   clk, reset                  system clock, synchronous active-high reset
//   usb_clk, usb_cs, usb_miosi  FT1248 bus from the master (sampled on clk)
//   usb_miso                    0 = ACK / byte accepted, 1 = NAK / busy
//   rx_read, rx_empty, rx_rdata host->device FIFO, local read side
//   tx_write, tx_wdata, tx_full device->host FIFO, local write side
//   host_reset                  bit0 of the byte returned by READ_MODEM_STATUS
//   reset_reply                 bit5 of the last WRITE_MODEM_STATUS byte
//   flush_seen                  one-cycle pulse per committed WRITE_BUFFER_FLUSH

module usb_ft1248_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until a push has happened.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end
endmodule

module usb_ft1248_device #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       usb_clk,
    input  logic       usb_cs,
    output logic       usb_miso,
    inout  wire  [7:0] usb_miosi,
    input  logic       rx_read,
    output logic       rx_empty,
    output logic [7:0] rx_rdata,
    input  logic       tx_write,
    input  logic [7:0] tx_wdata,
    output logic       tx_full,
    input  logic       host_reset,
    output logic       reset_reply,
    output logic       flush_seen
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COMMAND = 3'd1;
    localparam logic [2:0] ST_STATUS  = 3'd2;
    localparam logic [2:0] ST_DATA    = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    localparam logic [7:0] CMD_WRITE       = 8'h00;
    localparam logic [7:0] CMD_READ        = 8'h40;
    localparam logic [7:0] CMD_READ_MODEM  = 8'h20;
    localparam logic [7:0] CMD_WRITE_MODEM = 8'h60;
    localparam logic [7:0] CMD_FLUSH       = 8'h08;

    // Input stage and previous usb_clk for edge detection.
    logic       usb_clk_q, usb_clk_d;
    logic       usb_clk_prev_q, usb_clk_prev_d;
    logic       usb_cs_q, usb_cs_d;
    logic [7:0] miosi_in_q, miosi_in_d;

    // Protocol state.
    logic [2:0] state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] data_byte_q, data_byte_d;
    logic       first_q, first_d;
    logic       miso_q, miso_d;
    logic       miosi_oe_q, miosi_oe_d;
    logic [7:0] miosi_out_q, miosi_out_d;
    logic       reset_reply_q, reset_reply_d;
    logic       flush_seen_q, flush_seen_d;

    logic       rise, fall;
    logic       status_ack;
    logic       drives_bus;
    logic       rx_push, rx_full;
    logic       tx_pop, tx_empty;
    logic [7:0] tx_rdata;

    usb_ft1248_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .wdata (data_byte_q),
        .pop   (rx_read),
        .rdata (rx_rdata),
        .empty (rx_empty),
        .full  (rx_full)
    );

    usb_ft1248_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_write),
        .wdata (tx_wdata),
        .pop   (tx_pop),
        .rdata (tx_rdata),
        .empty (tx_empty),
        .full  (tx_full)
    );

    assign rise = usb_clk_q & ~usb_clk_prev_q;
    assign fall = ~usb_clk_q & usb_clk_prev_q;

    // Only the two read-type commands ever turn the bus around.
    assign drives_bus = (cmd_q == CMD_READ) || (cmd_q == CMD_READ_MODEM);

    always_comb begin
        case (cmd_q)
            CMD_WRITE:       status_ack = ~rx_full;
            CMD_READ:        status_ack = ~tx_empty;
            CMD_READ_MODEM,
            CMD_WRITE_MODEM,
            CMD_FLUSH:       status_ack = 1'b1;
            default:         status_ack = 1'b0;
        endcase
    end

    always_comb begin
        usb_clk_d      = usb_clk;
        usb_clk_prev_d = usb_clk_q;
        usb_cs_d       = usb_cs;
        miosi_in_d     = usb_miosi;
        state_d        = state_q;
        cmd_d          = cmd_q;
        data_byte_d    = data_byte_q;
        first_d        = first_q;
        miso_d         = miso_q;
        miosi_oe_d     = miosi_oe_q;
        miosi_out_d    = miosi_out_q;
        reset_reply_d  = reset_reply_q;
        flush_seen_d   = 1'b0;
        rx_push        = 1'b0;
        tx_pop         = 1'b0;

        if (usb_cs_q && (state_q != ST_IDLE)) begin
            // Deselect wins over any edge; an uncommitted byte is simply dropped.
            state_d    = ST_IDLE;
            miso_d     = 1'b1;
            miosi_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d     = 1'b1;
                    miosi_oe_d = 1'b0;
                    if (!usb_cs_q) begin
                        state_d = ST_COMMAND;
                    end
                end
                ST_COMMAND: begin
                    if (rise) begin
                        cmd_d = miosi_in_q;
                    end else if (fall) begin
                        state_d = ST_STATUS;
                    end
                end
                ST_STATUS: begin
                    if (rise) begin
                        miso_d     = ~status_ack;
                        miosi_oe_d = status_ack & drives_bus;
                    end else if (fall) begin
                        if (!miso_q) begin
                            state_d = ST_DATA;
                            first_d = 1'b1;
                        end else begin
                            state_d    = ST_HOLD;
                            miso_d     = 1'b1;
                            miosi_oe_d = 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (rise) begin
                        data_byte_d = miosi_in_q;
                        case (cmd_q)
                            CMD_READ: begin
                                miosi_out_d = tx_rdata;
                                miso_d      = tx_empty;
                            end
                            CMD_WRITE: begin
                                miso_d = rx_full;
                            end
                            CMD_READ_MODEM: begin
                                miosi_out_d = {7'b0, host_reset};
                                miso_d      = ~first_q;
                            end
                            default: begin
                                miso_d = ~first_q;
                            end
                        endcase
                    end else if (fall) begin
                        if (!miso_q) begin
                            first_d = 1'b0;
                            case (cmd_q)
                                CMD_WRITE:       rx_push       = 1'b1;
                                CMD_READ:        tx_pop        = 1'b1;
                                CMD_WRITE_MODEM: reset_reply_d = data_byte_q[5];
                                CMD_FLUSH:       flush_seen_d  = 1'b1;
                                default:         ;
                            endcase
                        end else begin
                            state_d    = ST_HOLD;
                            miso_d     = 1'b1;
                            miosi_oe_d = 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    miso_d     = 1'b1;
                    miosi_oe_d = 1'b0;
                end
                default: begin
                    state_d    = ST_IDLE;
                    miso_d     = 1'b1;
                    miosi_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            usb_clk_q      <= 1'b0;
            usb_clk_prev_q <= 1'b0;
            usb_cs_q       <= 1'b1;
            miosi_in_q     <= 8'h00;
            state_q        <= ST_IDLE;
            cmd_q          <= 8'h00;
            data_byte_q    <= 8'h00;
            first_q        <= 1'b0;
            miso_q         <= 1'b1;
            miosi_oe_q     <= 1'b0;
            miosi_out_q    <= 8'h00;
            reset_reply_q  <= 1'b0;
            flush_seen_q   <= 1'b0;
        end else begin
            usb_clk_q      <= usb_clk_d;
            usb_clk_prev_q <= usb_clk_prev_d;
            usb_cs_q       <= usb_cs_d;
            miosi_in_q     <= miosi_in_d;
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            data_byte_q    <= data_byte_d;
            first_q        <= first_d;
            miso_q         <= miso_d;
            miosi_oe_q     <= miosi_oe_d;
            miosi_out_q    <= miosi_out_d;
            reset_reply_q  <= reset_reply_d;
            flush_seen_q   <= flush_seen_d;
        end
    end

    assign usb_miso    = miso_q;
    assign usb_miosi   = miosi_oe_q ? miosi_out_q : {8{1'bz}};
    assign reset_reply = reset_reply_q;
    assign flush_seen  = flush_seen_q;
endmodule

// File: tb/tb_usb_ft1248_device.sv
// tb/tb_usb_ft1248_device.sv - directed bench for usb_ft1248_device with a queue-based bus model
module tb_usb_ft1248_device;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       usb_clk = 1'b0;
    logic       usb_cs = 1'b1;
    logic       rx_read = 1'b0;
    logic       tx_write = 1'b0;
    logic [7:0] tx_wdata = 8'h00;
    logic       host_reset = 1'b0;
    logic       usb_miso, rx_empty, tx_full, reset_reply, flush_seen;
    logic [7:0] rx_rdata;
    wire  [7:0] usb_miosi;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_data = 8'h00;

    assign usb_miosi = tb_oe ? tb_data : 8'hzz;

    usb_ft1248_device #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .usb_clk     (usb_clk),
        .usb_cs      (usb_cs),
        .usb_miso    (usb_miso),
        .usb_miosi   (usb_miosi),
        .rx_read     (rx_read),
        .rx_empty    (rx_empty),
        .rx_rdata    (rx_rdata),
        .tx_write    (tx_write),
        .tx_wdata    (tx_wdata),
        .tx_full     (tx_full),
        .host_reset  (host_reset),
        .reset_reply (reset_reply),
        .flush_seen  (flush_seen)
    );

    always #5 clk = ~clk;

    // Model state: FIFO contents as queues plus expected bus outputs.
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] wq[$];
    logic [7:0] rdq[$];
    logic       m_rr = 1'b0;
    logic       exp_miso = 1'b1;
    logic       exp_oe = 1'b0;
    logic       exp_byte_vld = 1'b0;
    logic [7:0] exp_byte = 8'h00;
    logic       last_status_miso = 1'b0;
    bit         chk_on = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         flush_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (flush_seen) flush_cnt++;
        if (chk_on) begin
            check("miso", usb_miso, exp_miso);
            check("miosi_oe", dut.miosi_oe_q, exp_oe);
            if (exp_oe && exp_byte_vld) check("miosi_byte", usb_miosi, exp_byte);
            check("rx_empty", rx_empty, rxq.size() == 0);
            if (rxq.size() != 0) check("rx_rdata", rx_rdata, rxq[0]);
            check("tx_full", tx_full, txq.size() == DEPTH);
            check("reset_reply", reset_reply, m_rr);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic edge_to(input logic v);
        chk_on = 1'b0;
        usb_clk = v;
        cyc(3);
    endtask

    task automatic push_tx(input logic [7:0] b);
        chk_on = 1'b0;
        tx_wdata = b;
        tx_write = 1'b1;
        cyc(1);
        tx_write = 1'b0;
        txq.push_back(b);
        chk_on = 1'b1;
    endtask

    task automatic pop_rx(input logic [7:0] lit);
        chk_on = 1'b0;
        check("rx_head_lit", rx_rdata, lit);
        rx_read = 1'b1;
        cyc(1);
        rx_read = 1'b0;
        if (rxq.size() != 0) void'(rxq.pop_front());
        chk_on = 1'b1;
        cyc(1);
    endtask

    task automatic txn(input logic [7:0] cmd, input int n, input int abort_at);
        logic ack, ok, rd_type;
        rd_type = (cmd == 8'h40) || (cmd == 8'h20);
        chk_on = 1'b0;
        usb_cs = 1'b0;
        cyc(3);
        exp_miso = 1'b1; exp_oe = 1'b0; exp_byte_vld = 1'b0;
        chk_on = 1'b1; cyc(2);
        tb_oe = 1'b1; tb_data = cmd;
        edge_to(1'b1); chk_on = 1'b1; cyc(2);
        edge_to(1'b0); chk_on = 1'b1; cyc(2);
        if (rd_type) tb_oe = 1'b0;
        case (cmd)
            8'h00:               ack = rxq.size() < DEPTH;
            8'h40:               ack = txq.size() != 0;
            8'h20, 8'h60, 8'h08: ack = 1'b1;
            default:             ack = 1'b0;
        endcase
        edge_to(1'b1);
        exp_miso = !ack; exp_oe = ack && rd_type;
        last_status_miso = usb_miso;
        chk_on = 1'b1; cyc(2);
        edge_to(1'b0); chk_on = 1'b1; cyc(2);
        if (ack) begin
            for (int i = 0; i < n; i++) begin
                if (!rd_type) tb_data = (i < wq.size()) ? wq[i] : 8'h00;
                case (cmd)
                    8'h00:   ok = rxq.size() < DEPTH;
                    8'h40:   ok = txq.size() != 0;
                    default: ok = (i == 0);
                endcase
                exp_byte_vld = 1'b0;
                if (cmd == 8'h40 && ok) begin exp_byte = txq[0]; exp_byte_vld = 1'b1; end
                if (cmd == 8'h20) begin exp_byte = {7'b0, host_reset}; exp_byte_vld = 1'b1; end
                edge_to(1'b1);
                exp_miso = !ok;
                if (rd_type && ok) rdq.push_back(usb_miosi);
                chk_on = 1'b1; cyc(2);
                if (i == abort_at) break;
                edge_to(1'b0);
                if (ok) begin
                    case (cmd)
                        8'h00:   rxq.push_back(tb_data);
                        8'h40:   void'(txq.pop_front());
                        8'h60:   m_rr = tb_data[5];
                        default: ;
                    endcase
                end else begin
                    exp_miso = 1'b1; exp_oe = 1'b0; exp_byte_vld = 1'b0;
                end
                chk_on = 1'b1; cyc(2);
                if (!ok) break;
            end
        end else begin
            // Clock edges while held must change nothing.
            repeat (2) begin
                edge_to(1'b1); chk_on = 1'b1; cyc(2);
                edge_to(1'b0); chk_on = 1'b1; cyc(2);
            end
        end
        chk_on = 1'b0;
        usb_cs = 1'b1; tb_oe = 1'b0;
        cyc(3);
        usb_clk = 1'b0;
        exp_miso = 1'b1; exp_oe = 1'b0; exp_byte_vld = 1'b0;
        chk_on = 1'b1; cyc(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        check("rst_miso", usb_miso, 1);
        check("rst_oe", dut.miosi_oe_q, 0);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_tx_full", tx_full, 0);
        check("rst_reset_reply", reset_reply, 0);
        check("rst_flush", flush_seen, 0);
        reset = 1'b0;
        cyc(2);
        chk_on = 1'b1;
        cyc(2);

        // Host->device write of three bytes.
        wq = '{8'hA1, 8'hB2, 8'hC3};
        txn(8'h00, 3, -1);
        check("wr_status_ack", last_status_miso, 0);
        check("wr_rx_nonempty", rx_empty, 0);
        pop_rx(8'hA1); pop_rx(8'hB2); pop_rx(8'hC3);
        check("wr_rx_drained", rx_empty, 1);

        // Device->host read: two bytes then a busy byte.
        push_tx(8'h11); push_tx(8'h22);
        rdq.delete();
        txn(8'h40, 3, -1);
        check("rd_count", rdq.size(), 2);
        if (rdq.size() == 2) begin
            check("rd_byte0", rdq[0], 8'h11);
            check("rd_byte1", rdq[1], 8'h22);
        end

        // TX now empty: READ is refused.
        txn(8'h40, 1, -1);
        check("rd_empty_nak", last_status_miso, 1);

        // Modem status.
        host_reset = 1'b1;
        rdq.delete();
        txn(8'h20, 1, -1);
        check("rms_count", rdq.size(), 1);
        if (rdq.size() == 1) check("rms_byte", rdq[0], 8'h01);
        host_reset = 1'b0;
        wq = '{8'h20};
        txn(8'h60, 1, -1);
        check("wms_set", reset_reply, 1);
        wq = '{8'h00};
        txn(8'h60, 1, -1);
        check("wms_clear", reset_reply, 0);

        // Fill RX; the 17th byte is refused and a new WRITE is NAKed.
        wq.delete();
        for (int i = 0; i < DEPTH + 1; i++) wq.push_back(8'(i * 7 + 3));
        txn(8'h00, DEPTH + 1, -1);
        txn(8'h00, 1, -1);
        check("full_nak", last_status_miso, 1);
        for (int i = 0; i < DEPTH; i++) pop_rx(8'(i * 7 + 3));
        check("full_drained", rx_empty, 1);

        // Unknown command.
        txn(8'h55, 1, -1);
        check("unknown_nak", last_status_miso, 1);

        // Deselect between rise and fall of the second byte.
        wq = '{8'h5A, 8'h6B};
        txn(8'h00, 2, 1);
        pop_rx(8'h5A);
        check("abort_one_byte", rx_empty, 1);

        // Flush pulses once.
        flush_cnt = 0;
        txn(8'h08, 2, -1);
        check("flush_pulses", flush_cnt, 1);

        // Reset in the middle of a transaction clears everything.
        push_tx(8'h77);
        wq = '{8'h33};
        txn(8'h00, 1, -1);
        chk_on = 1'b0;
        usb_cs = 1'b0; cyc(3);
        tb_oe = 1'b1; tb_data = 8'h40; usb_clk = 1'b1; cyc(3);
        reset = 1'b1; cyc(1); reset = 1'b0;
        rxq.delete(); txq.delete(); m_rr = 1'b0;
        cyc(1);
        check("midrst_miso", usb_miso, 1);
        check("midrst_oe", dut.miosi_oe_q, 0);
        check("midrst_rx_empty", rx_empty, 1);
        usb_cs = 1'b1; tb_oe = 1'b0; cyc(3); usb_clk = 1'b0; cyc(3);
        exp_miso = 1'b1; exp_oe = 1'b0; exp_byte_vld = 1'b0;
        chk_on = 1'b1;
        txn(8'h40, 1, -1);
        check("midrst_tx_cleared", last_status_miso, 1);

        chk_on = 1'b0;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
